// File: rtl/fwrisc_mem_arbiter.sv
// fwrisc_mem_arbiter: shares one memory port between fetch and data.
// Define FWRISC_MEM_ARB_RR_EN for round-robin contention handling.
module fwrisc_mem_arbiter #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] iaddr,
  input  logic        ivalid,
  output logic        iready,
  output logic [31:0] idata,
  input  logic [31:0] daddr,
  input  logic [31:0] dwdata,
  input  logic [3:0]  dstrb,
  input  logic        dwrite,
  input  logic        dvalid,
  output logic        dready,
  output logic [31:0] drdata,
  output logic [31:0] maddr,
  output logic [31:0] mwdata,
  output logic [3:0]  mstrb,
  output logic        mwrite,
  output logic        mvalid,
  input  logic        mready,
  input  logic [31:0] mrdata,
  output logic        merr
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_GNT_I,
    ST_GNT_D
  } state_t;

  localparam logic [7:0] LP_TO_LAST = 8'(TIMEOUT_CYCLES - 1);

  state_t     r_state;
  logic [7:0] r_wait;

  logic w_gnt_i;
  logic w_gnt_d;
  logic w_req;
  logic w_vld;
  logic w_done;
  logic w_to;
  logic w_pick_d;

  assign w_gnt_i = (r_state == ST_GNT_I);
  assign w_gnt_d = (r_state == ST_GNT_D);
  assign w_req   = ivalid | dvalid;
  assign w_vld   = (w_gnt_i & ivalid) | (w_gnt_d & dvalid);
  assign w_done  = w_vld & mready;
  // mready in the last allowed cycle wins over the timeout
  assign w_to    = w_vld & ~mready & (r_wait == LP_TO_LAST);

`ifdef FWRISC_MEM_ARB_RR_EN
  logic r_last_d;

  assign w_pick_d = dvalid & (~ivalid | ~r_last_d);

  // remember who was granted last to alternate under contention
  always_ff @(posedge clock) begin
    if (reset) begin
      r_last_d <= 1'b0;
    end else if (r_state == ST_IDLE && w_req) begin
      r_last_d <= w_pick_d;
    end
  end
`else
  assign w_pick_d = dvalid;
`endif

  // grant FSM and wait counter; one transfer outstanding at a time
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_wait  <= 8'd0;
    end else begin
      unique case (r_state)
        ST_IDLE: begin
          r_wait <= 8'd0;
          if (w_req) begin
            r_state <= w_pick_d ? ST_GNT_D : ST_GNT_I;
          end
        end
        ST_GNT_I,
        ST_GNT_D: begin
          if (!w_vld || w_done || w_to) begin
            r_state <= ST_IDLE;
          end else begin
            r_wait <= r_wait + 8'd1;
          end
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign mvalid = w_vld;
  assign iready = w_gnt_i & (w_done | w_to);
  assign dready = w_gnt_d & (w_done | w_to);
  assign merr   = w_to;

  assign maddr  = w_gnt_d ? daddr :
                  w_gnt_i ? iaddr : 32'd0;
  assign mwdata = w_gnt_d ? dwdata : 32'd0;
  assign mstrb  = w_gnt_d ? dstrb :
                  w_gnt_i ? 4'hf : 4'h0;
  assign mwrite = w_gnt_d & dwrite;

  assign idata  = w_to ? 32'd0 : mrdata;
  assign drdata = w_to ? 32'd0 : mrdata;

endmodule

// File: tb/tb_fwrisc_mem_arbiter.sv
// tb_fwrisc_mem_arbiter: scoreboard bench for the memory arbiter.
// Expected completions are queued at issue; a monitor pops on ready.
module tb_fwrisc_mem_arbiter;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] iaddr;
  logic        ivalid;
  logic        iready;
  logic [31:0] idata;
  logic [31:0] daddr;
  logic [31:0] dwdata;
  logic [3:0]  dstrb;
  logic        dwrite;
  logic        dvalid;
  logic        dready;
  logic [31:0] drdata;
  logic [31:0] maddr;
  logic [31:0] mwdata;
  logic [3:0]  mstrb;
  logic        mwrite;
  logic        mvalid;
  logic        mready;
  logic [31:0] mrdata;
  logic        merr;

  fwrisc_mem_arbiter #(.TIMEOUT_CYCLES(TO)) dut (
    .clock  (clk),
    .reset  (reset),
    .iaddr  (iaddr),
    .ivalid (ivalid),
    .iready (iready),
    .idata  (idata),
    .daddr  (daddr),
    .dwdata (dwdata),
    .dstrb  (dstrb),
    .dwrite (dwrite),
    .dvalid (dvalid),
    .dready (dready),
    .drdata (drdata),
    .maddr  (maddr),
    .mwdata (mwdata),
    .mstrb  (mstrb),
    .mwrite (mwrite),
    .mvalid (mvalid),
    .mready (mready),
    .mrdata (mrdata),
    .merr   (merr)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          is_d;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic [3:0]  strb;
    logic        wr;
    logic        err;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   fails  = 0;
  bit   last_d = 1'b0;

  function automatic void chk(string n, logic [31:0] a, logic [31:0] e);
    checks++;
    if (a !== e) begin
      fails++;
      $display("FAIL %s got=%h exp=%h t=%0t", n, a, e, $time);
    end
  endfunction

  function automatic void push(bit is_d, int lat, logic [31:0] rd);
    exp_t e;
    e.is_d  = is_d;
    e.addr  = is_d ? daddr : iaddr;
    e.wr    = is_d ? dwrite : 1'b0;
    e.strb  = is_d ? dstrb : 4'hf;
    e.wdata = is_d ? dwdata : 32'd0;
    e.err   = (lat > TO - 1);
    e.rdata = e.err ? 32'd0 : rd;
    sb.push_back(e);
  endfunction

  // Both requesters present: who goes first
  function automatic bit pick_d();
`ifdef FWRISC_MEM_ARB_RR_EN
    return !last_d;
`else
    return 1'b1;
`endif
  endfunction

  // monitor: every completion must match the queued expectation
  always @(negedge clk) begin
    if (reset === 1'b0 && (iready === 1'b1 || dready === 1'b1 || merr === 1'b1)) begin
      if (sb.size() == 0) begin
        checks++;
        fails++;
        $display("FAIL unexpected_resp iready=%b dready=%b merr=%b", iready, dready, merr);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("one_ready", 32'(iready ^ dready), 32'd1);
        chk("who_d", 32'(dready), 32'(e.is_d));
        chk("mvalid", 32'(mvalid), 32'd1);
        chk("maddr", maddr, e.addr);
        chk("mwrite", 32'(mwrite), 32'(e.wr));
        chk("mstrb", 32'(mstrb), 32'(e.strb));
        chk("mwdata", mwdata, e.wdata);
        chk("rdata", e.is_d ? drdata : idata, e.rdata);
        chk("merr", 32'(merr), 32'(e.err));
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_noise();
    mready = 1'($urandom_range(0, 1));
    mrdata = $urandom;
  endtask

  task automatic set_i();
    iaddr = $urandom;
  endtask

  task automatic set_d();
    daddr  = $urandom;
    dwdata = $urandom;
    dstrb  = 4'($urandom);
    dwrite = 1'($urandom);
  endtask

  // run one granted transfer from its arbitration cycle to the next IDLE
  task automatic serve(input bit is_d, input int lat, input logic [31:0] rd);
    int kend;
    kend = (lat > TO - 1) ? TO - 1 : lat;
    for (int k = 0; k <= kend; k++) begin
      cyc();
      mready = (k == lat);
      mrdata = (k == lat) ? rd : $urandom;
    end
    cyc();
    if (is_d) dvalid = 1'b0;
    else      ivalid = 1'b0;
    idle_noise();
  endtask

  task automatic single(input bit is_d, input int lat, input logic [31:0] rd);
    if (is_d) dvalid = 1'b1;
    else      ivalid = 1'b1;
    push(is_d, lat, rd);
    last_d = is_d;
    serve(is_d, lat, rd);
  endtask

  task automatic both(input int l1, input int l2,
                      input logic [31:0] r1, input logic [31:0] r2);
    bit w;
    ivalid = 1'b1;
    dvalid = 1'b1;
    w = pick_d();
    push(w, l1, r1);
    push(!w, l2, r2);
    serve(w, l1, r1);
    serve(!w, l2, r2);
    last_d = !w;
  endtask

  task automatic withdraw(input bit is_d, input int wk);
    if (is_d) dvalid = 1'b1;
    else      ivalid = 1'b1;
    last_d = is_d;
    for (int k = 0; k <= wk; k++) begin
      cyc();
      mready = 1'b0;
      mrdata = $urandom;
    end
    if (is_d) dvalid = 1'b0;
    else      ivalid = 1'b0;
    #1;
    chk("wd_mvalid", 32'(mvalid), 32'd0);
    cyc();
    idle_noise();
  endtask

  task automatic reset_mid();
    set_d();
    dvalid = 1'b1;
    cyc();
    mready = 1'b0;
    cyc();
    reset = 1'b1;
    cyc();
    reset  = 1'b0;
    dvalid = 1'b0;
    last_d = 1'b0;
    #1;
    chk("rm_mvalid", 32'(mvalid), 32'd0);
    chk("rm_dready", 32'(dready), 32'd0);
    chk("rm_merr", 32'(merr), 32'd0);
  endtask

  initial begin
    reset  = 1'b1;
    iaddr  = '0;
    ivalid = 1'b0;
    daddr  = '0;
    dwdata = '0;
    dstrb  = '0;
    dwrite = 1'b0;
    dvalid = 1'b0;
    mready = 1'b0;
    mrdata = '0;
    cyc();
    cyc();
    chk("rst_mvalid", 32'(mvalid), 32'd0);
    chk("rst_iready", 32'(iready), 32'd0);
    chk("rst_dready", 32'(dready), 32'd0);
    chk("rst_merr", 32'(merr), 32'd0);
    chk("rst_mwrite", 32'(mwrite), 32'd0);
    reset = 1'b0;

    iaddr = 32'h8000_0000;
    single(1'b0, 1, 32'h0000_0013);

    set_i();
    daddr  = 32'h100;
    dwdata = 32'hcafe_f00d;
    dwrite = 1'b1;
    dstrb  = 4'b0011;
    both(0, 2, $urandom, $urandom);
    set_i();
    set_d();
    both(1, 0, $urandom, $urandom);

    set_d();
    single(1'b1, 9, $urandom);
    set_d();
    single(1'b1, TO - 1, $urandom);
    set_i();
    withdraw(1'b0, 1);
    reset_mid();
    set_d();
    single(1'b1, 0, $urandom);

    for (int n = 0; n < 200; n++) begin
      int kind;
      kind = $urandom_range(0, 9);
      set_i();
      set_d();
      if (kind <= 3) begin
        single(1'($urandom), $urandom_range(0, 5), $urandom);
      end else if (kind <= 6) begin
        both($urandom_range(0, 5), $urandom_range(0, 5), $urandom, $urandom);
      end else if (kind <= 8) begin
        withdraw(1'($urandom), $urandom_range(0, TO - 2));
      end else begin
        reset_mid();
      end
    end

    mready = 1'b0;
    repeat (3) cyc();
    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
